// File: rtl/mitchell_mult_pipe.sv
// Pipelined Mitchell logarithmic multiplier: input capture, LOD, log-domain add, antilog shift.
// Valid/ready handshake; every stage stalls together when the output is held.

module mitchell_lod #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = WIDTH-1,
  parameter int KW        = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     i_mag,
  output logic [KW-1:0]        o_k,
  output logic [FRAC_BITS-1:0] o_f
);
  logic [KW-1:0]    w_shamt;
  logic [WIDTH-1:0] w_norm;

  always_comb begin
    o_k = '0;
    for (int i = 0; i < WIDTH; i++)
      if (i_mag[i]) o_k = KW'(i);
  end

  // Shift leading one to the MSB; the bits below it are the mantissa, top FRAC_BITS kept.
  assign w_shamt = KW'(WIDTH-1) - o_k;
  assign w_norm  = i_mag << w_shamt;
  assign o_f     = FRAC_BITS'(w_norm >> (WIDTH-1-FRAC_BITS));
endmodule

module mitchell_mult_pipe #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = WIDTH-1,
  parameter int SIGNED    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               zero
);
  localparam int KW     = $clog2(WIDTH);
  localparam int SW     = KW + 1;
  localparam int PW     = 2 * WIDTH;
  localparam int STAGES = 3;

  logic              w_adv;
  logic [STAGES:0]   r_vld_pipe;

  logic [WIDTH-1:0]  r_a0, r_b0;
  logic [1:0][WIDTH-1:0]     w_opnd, w_mag;
  logic [1:0][KW-1:0]        w_k;
  logic [1:0][FRAC_BITS-1:0] w_f;
  logic              w_sign0, w_zero0;

  logic [1:0][KW-1:0]        r_k1;
  logic [1:0][FRAC_BITS-1:0] r_f1;
  logic              r_sign1, r_zero1;

  logic [SW-1:0]     r_k2;
  logic [FRAC_BITS:0] r_f2;
  logic              r_sign2, r_zero2;

  logic [SW-1:0]     w_e;
  logic [FRAC_BITS:0] w_m;
  logic [PW+FRAC_BITS-1:0] w_wide;
  logic [PW-1:0]     w_prod_mag, w_prod;

  logic [PW-1:0]     r_p;
  logic              r_zero;

  assign w_adv     = out_ready | ~r_vld_pipe[STAGES];
  assign in_ready  = w_adv;
  assign out_valid = r_vld_pipe[STAGES];
  assign p         = r_p;
  assign zero      = r_zero;

  // S1: sign-magnitude split and leading-one detect per operand.
  assign w_opnd  = {r_b0, r_a0};
  assign w_sign0 = (SIGNED != 0) & (r_a0[WIDTH-1] ^ r_b0[WIDTH-1]);
  assign w_zero0 = (r_a0 == '0) | (r_b0 == '0);

  for (genvar g = 0; g < 2; g++) begin : g_op
    assign w_mag[g] = ((SIGNED != 0) && w_opnd[g][WIDTH-1]) ? -w_opnd[g] : w_opnd[g];
    mitchell_lod #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .KW(KW)) u_lod (
      .i_mag (w_mag[g]),
      .o_k   (w_k[g]),
      .o_f   (w_f[g])
    );
  end

  // S3: a mantissa carry means fA+fB = 1+F', i.e. 2^(K+1)*(1+F').
  assign w_e        = r_k2 + SW'(r_f2[FRAC_BITS]);
  assign w_m        = {1'b1, r_f2[FRAC_BITS-1:0]};
  assign w_wide     = (PW+FRAC_BITS)'(w_m) << w_e;
  assign w_prod_mag = PW'(w_wide >> FRAC_BITS);
  assign w_prod     = r_zero2 ? '0 : (((SIGNED != 0) && r_sign2) ? -w_prod_mag : w_prod_mag);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_p        <= '0;
      r_zero     <= 1'b0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], in_valid};
      if (r_vld_pipe[STAGES-1]) begin
        r_p    <= w_prod;
        r_zero <= r_zero2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_a0    <= a;
      r_b0    <= b;
      r_k1    <= w_k;
      r_f1    <= w_f;
      r_sign1 <= w_sign0;
      r_zero1 <= w_zero0;
      r_k2    <= SW'(r_k1[0]) + SW'(r_k1[1]);
      r_f2    <= (FRAC_BITS+1)'(r_f1[0]) + (FRAC_BITS+1)'(r_f1[1]);
      r_sign2 <= r_sign1;
      r_zero2 <= r_zero1;
    end
  end
endmodule

// File: tb/tb_mitchell_mult_pipe.sv
// Bench for mitchell_mult_pipe: three configurations (unsigned, signed, 3 fraction bits)
// checked by constant vectors, timed sequences and a scoreboard fed from an arithmetic model.

module tb_mitchell_mult_pipe;
  localparam int W  = 8;
  localparam int NU = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NU-1:0] iv, ir, ov, ordy, zr;
  logic [W-1:0]  av [NU];
  logic [W-1:0]  bv [NU];
  logic [2*W-1:0] pv [NU];

  int checks   = 0;
  int failures = 0;

  int cfg_nf [NU] = '{7, 7, 3};
  bit cfg_s  [NU] = '{1'b0, 1'b1, 1'b0};

  mitchell_mult_pipe #(.WIDTH(W), .FRAC_BITS(7), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .p(pv[0]), .zero(zr[0]));
  mitchell_mult_pipe #(.WIDTH(W), .FRAC_BITS(7), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .p(pv[1]), .zero(zr[1]));
  mitchell_mult_pipe #(.WIDTH(W), .FRAC_BITS(3), .SIGNED(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(av[2]), .b(bv[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .p(pv[2]), .zero(zr[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Mitchell approximation from log2 / fraction arithmetic; returns {zero, p}.
  function automatic logic [16:0] model(input int nf, input bit sg, input logic [7:0] x, input logic [7:0] y);
    longint ma, mb, ka, kb, fa, fbv, fs, ks, mag, one;
    int sx, sy;
    bit neg;
    one = 1;
    if (x == 0 || y == 0) return {1'b1, 16'h0};
    if (sg) begin
      sx = $signed(x); sy = $signed(y);
      neg = (sx < 0) ^ (sy < 0);
      ma = (sx < 0) ? -sx : sx;
      mb = (sy < 0) ? -sy : sy;
    end else begin
      ma = longint'(x); mb = longint'(y); neg = 1'b0;
    end
    ka = 0; while ((one << (ka+1)) <= ma) ka++;
    kb = 0; while ((one << (kb+1)) <= mb) kb++;
    fa  = ((ma - (one << ka)) << nf) >> ka;
    fbv = ((mb - (one << kb)) << nf) >> kb;
    fs = fa + fbv;
    ks = ka + kb;
    if (fs < (one << nf)) mag = (((one << nf) + fs) << ks) >> nf;
    else                  mag = (fs << (ks+1)) >> nf;
    if (neg) mag = -mag;
    return {1'b0, mag[15:0]};
  endfunction

  function automatic logic [7:0] rnd();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  // Scoreboard: ordering, hold stability under backpressure, no spurious outputs.
  logic [16:0] sbq [NU][$];
  logic [16:0] held [NU];
  bit          hold_v [NU];
  int          popped [NU] = '{0, 0, 0};

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NU; i++) begin sbq[i].delete(); hold_v[i] = 1'b0; end
    end else begin
      for (int i = 0; i < NU; i++) begin
        if (hold_v[i]) begin
          chk($sformatf("hold_valid%0d", i), 32'(ov[i]), 32'd1);
          chk($sformatf("hold_data%0d", i), 32'({zr[i], pv[i]}), 32'(held[i]));
        end
        if (ov[i] && ordy[i]) begin
          if (sbq[i].size() == 0) chk($sformatf("spurious_out%0d", i), 32'({zr[i], pv[i]}), 32'h1FFFF);
          else chk($sformatf("sb%0d", i), 32'({zr[i], pv[i]}), 32'(sbq[i].pop_front()));
          popped[i]++;
        end
        if (iv[i] && ir[i]) sbq[i].push_back(model(cfg_nf[i], cfg_s[i], av[i], bv[i]));
        hold_v[i] = ov[i] && !ordy[i];
        held[i]   = {zr[i], pv[i]};
      end
    end
  end

  task automatic apply_one(input int d, input logic [7:0] x, input logic [7:0] y,
                           input logic [15:0] ep, input logic ez, input string nm);
    int n;
    @(posedge clk); #1;
    iv[d] = 1'b1; av[d] = x; bv[d] = y; ordy[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    n = 0;
    while (!ov[d] && n < 8) begin @(posedge clk); #1; n++; end
    if (!ov[d]) chk({nm, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({nm, "_p"}, 32'(pv[d]), 32'(ep));
      chk({nm, "_zero"}, 32'(zr[d]), 32'(ez));
    end
  endtask

  typedef struct {
    int          d;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        z;
  } vec_t;

  vec_t tbl [14];
  logic [7:0]  t1a [4] = '{8'd5, 8'd15, 8'd129, 8'd255};
  logic [7:0]  t1b [4] = '{8'd3, 8'd5, 8'd65, 8'd255};
  logic [15:0] t1p [4] = '{16'd14, 16'd72, 16'd8384, 16'd65024};

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int sent, p0;
    bit acc;
    tbl = '{
      '{0, 8'd0,   8'd18,  16'd0,     1'b1},
      '{0, 8'd18,  8'd0,   16'd0,     1'b1},
      '{0, 8'd1,   8'd1,   16'd1,     1'b0},
      '{0, 8'd8,   8'd2,   16'd16,    1'b0},
      '{0, 8'd255, 8'd255, 16'd65024, 1'b0},
      '{0, 8'd128, 8'd64,  16'd8192,  1'b0},
      '{1, 8'hFB,  8'd3,   16'hFFF2,  1'b0},
      '{1, 8'h80,  8'h80,  16'd16384, 1'b0},
      '{1, 8'hFF,  8'd1,   16'hFFFF,  1'b0},
      '{1, 8'h7F,  8'h80,  16'hC080,  1'b0},
      '{1, 8'd0,   8'hF0,  16'd0,     1'b1},
      '{2, 8'd15,  8'd5,   16'd72,    1'b0},
      '{2, 8'd255, 8'd255, 16'd57344, 1'b0},
      '{2, 8'd7,   8'd7,   16'd48,    1'b0}
    };

    rst = 1'b1; iv = '0; ordy = '1;
    for (int i = 0; i < NU; i++) begin av[i] = '0; bv[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_zero", 32'(zr), 32'd0);
    chk("rst_p0", 32'(pv[0]), 32'd0);
    chk("rst_in_ready", 32'(ir), 32'(3'b111));

    // Back-to-back stream: first product exactly 3 edges after its accept.
    @(posedge clk); #1;
    iv[0] = 1'b1; av[0] = t1a[0]; bv[0] = t1b[0];
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c < 3) begin av[0] = t1a[c+1]; bv[0] = t1b[c+1]; end
      else iv[0] = 1'b0;
      if (c >= 3 && c < 7) begin
        chk("lat_valid", 32'(ov[0]), 32'd1);
        chk("lat_p", 32'(pv[0]), 32'(t1p[c-3]));
      end else chk("lat_idle", 32'(ov[0]), 32'd0);
    end

    for (int k = 0; k < 14; k++)
      apply_one(tbl[k].d, tbl[k].a, tbl[k].b, tbl[k].p, tbl[k].z, $sformatf("tbl%0d", k));

    // Backpressure: consumer stalls for cycles 4-7 while 6 pairs stream in.
    sent = 0; p0 = popped[0];
    @(posedge clk); #1;
    iv[0] = 1'b1; av[0] = rnd(); bv[0] = rnd();
    for (int c = 0; c < 24; c++) begin
      ordy[0] = !(c >= 4 && c <= 7);
      @(negedge clk);
      if (c >= 4 && c <= 7) chk("bp_in_ready", 32'(ir[0]), 32'd0);
      acc = iv[0] && ir[0];
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 6) begin av[0] = rnd(); bv[0] = rnd(); end
        else iv[0] = 1'b0;
      end
    end
    chk("bp_sent", 32'(sent), 32'd6);
    chk("bp_count", 32'(popped[0] - p0), 32'd6);

    // Random traffic on all three configurations.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NU; i++) begin
        iv[i]   = ($urandom_range(0, 3) != 0);
        ordy[i] = ($urandom_range(0, 3) != 0);
        av[i]   = rnd();
        bv[i]   = rnd();
      end
    end
    @(posedge clk); #1;
    iv = '0; ordy = '1;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < NU; i++) chk($sformatf("drain%0d", i), 32'(sbq[i].size()), 32'd0);

    // Reset with three products in flight.
    @(posedge clk); #1;
    iv[0] = 1'b1; av[0] = 8'd7; bv[0] = 8'd9;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      av[0] = 8'd20 + 8'(k); bv[0] = 8'd3;
    end
    iv[0] = 1'b0; rst = 1'b1;
    chk("rstmid_pre", 32'(ov[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_valid", 32'(ov), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rstmid_quiet", 32'(ov), 32'd0);
    end
    apply_one(0, 8'd15, 8'd5, 16'd72, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
